if_fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the immediate extender.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents the fetched word to decode with a valid/ready handshake; decode feeds instr[15:0] to the extender.
- Takes the extender's 32-bit result back as branch_offset to compute branch targets.

---
 rtl/if_fetch_unit_if.sv | 28 ++
 rtl/if_fetch_unit.sv | 93 +++++++++
 tb/tb_if_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Bundles the instruction-memory and decode-side signals of the fetch stage.
// The master modport is the fetch unit. The slave modport is memory plus decode.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        id_ready;
  logic [31:0] instr_pc;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, instr_pc,
    input  imem_ack, imem_rdata, id_ready, branch_taken, branch_offset,
           jump, jump_index
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, instr_pc,
    output imem_ack, imem_rdata, id_ready, branch_taken, branch_offset,
           jump, jump_index
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: it fetches words over req/ack and holds one instruction for decode.
// It resolves the jump or branch redirect when decode consumes that instruction.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  if_fetch_unit_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] instr_pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        consume;

  assign instr_pc_plus4 = instr_pc_q + 32'd4;
  assign branch_target  = instr_pc_plus4 + {bus.branch_offset[29:0], 2'b00};
  assign jump_target    = {instr_pc_plus4[31:28], bus.jump_index, 2'b00};
  assign consume        = (state_q == ST_HOLD) && bus.id_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (consume) begin
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
          // Jump outranks branch. Otherwise pc_q already holds instr_pc + 4.
          if (bus.jump) begin
            pc_d = jump_target;
          end else if (bus.branch_taken) begin
            pc_d = branch_target;
          end
        end
      end
      default: begin
        state_d       = ST_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // The request decodes straight from the state flop, so asserting reset drops it at once.
  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit. A random memory and a random decode side drive the unit.
// The expected fetch address comes from a pc model that applies the redirect rules arithmetically.
module tb_if_fetch_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] exp_pc;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // Next pc after a consume, computed from the architectural rules.
  function automatic logic [31:0] model_next(input logic [31:0] ipc, input bit jmp,
                                             input bit br, input logic [31:0] off,
                                             input logic [25:0] idx);
    logic [31:0] seq;
    seq = ipc + 32'd4;
    if (jmp)     return (seq & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
    else if (br) return seq + off * 32'd4;
    else         return seq;
  endfunction

  task automatic run_instr(input int wait_n, input int stall_n, input bit jmp, input bit br,
                           input logic [31:0] off, input logic [25:0] idx, input string tag,
                           output int req_wait);
    logic [31:0] data;
    req_wait = 0;
    while (bus.imem_req !== 1'b1 && req_wait < 20) begin
      bus.id_ready = 1'($urandom_range(0, 1));
      bus.jump = 1'($urandom_range(0, 1));
      bus.branch_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      req_wait++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s req_timeout: imem_req=%b required 1", tag, bus.imem_req);
    end
    checks++;
    if (bus.imem_addr !== exp_pc) begin
      errors++;
      $display("FAIL %s fetch_addr: got %h required %h", tag, bus.imem_addr, exp_pc);
    end
    data = $urandom;
    for (int i = 0; i < wait_n; i++) begin
      bus.imem_ack = 1'b0;
      bus.imem_rdata = $urandom;
      bus.id_ready = 1'($urandom_range(0, 1));
      bus.jump = 1'($urandom_range(0, 1));
      bus.branch_taken = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_pc || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s wait_state: req=%b addr=%h valid=%b required 1 %h 0",
                 tag, bus.imem_req, bus.imem_addr, bus.instr_valid, exp_pc);
      end
    end
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    bus.id_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.imem_rdata = $urandom;
    bus.id_ready = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.instr_pc !== exp_pc ||
        bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s hold_entry: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
               tag, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, data, exp_pc);
    end
    for (int i = 0; i < stall_n; i++) begin
      bus.jump = 1'($urandom_range(0, 1));
      bus.branch_taken = 1'($urandom_range(0, 1));
      bus.branch_offset = $urandom;
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr !== data || bus.instr_pc !== exp_pc ||
          bus.imem_req !== 1'b0) begin
        errors++;
        $display("FAIL %s stall: valid=%b instr=%h pc=%h req=%b required 1 %h %h 0",
                 tag, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req, data, exp_pc);
      end
    end
    bus.id_ready = 1'b1;
    bus.jump = jmp;
    bus.branch_taken = br;
    bus.branch_offset = off;
    bus.jump_index = idx;
    @(negedge clk);
    bus.id_ready = 1'b0;
    bus.jump = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_offset = $urandom;
    bus.jump_index = 26'($urandom);
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s consume: valid=%b required 0", tag, bus.instr_valid);
    end
    exp_pc = model_next(exp_pc, jmp, br, off, idx);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 ||
        bus.instr_pc !== 32'd0 || bus.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h addr=%h required all 0",
               bus.imem_req, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr);
    end
    @(negedge clk);
    bus.id_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: req=%b required 0", bus.imem_req);
    end
    @(negedge clk);
    bus.id_ready = 1'b0;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_first_fetch: req=%b addr=%h required 1 00000000",
               bus.imem_req, bus.imem_addr);
    end
    exp_pc = 32'd0;
  endtask

  task automatic test_sequential();
    int rw;
    for (int i = 0; i < 4; i++) begin
      run_instr(0, 0, 1'b0, 1'b0, 32'd0, 26'd0, "sequential", rw);
      checks++;
      if (rw != 0 || bus.imem_addr !== 32'(4 * (i + 1))) begin
        errors++;
        $display("FAIL sequential_rate: gap=%0d addr=%h required 0 %h", rw, bus.imem_addr, 4 * (i + 1));
      end
    end
  endtask

  task automatic test_wait_states();
    int rw;
    run_instr(3, 0, 1'b0, 1'b0, 32'd0, 26'd0, "wait_states", rw);
  endtask

  task automatic test_backpressure();
    int rw;
    run_instr(0, 5, 1'b0, 1'b0, 32'd0, 26'd0, "backpressure", rw);
  endtask

  task automatic test_branch();
    int rw;
    run_instr(0, 0, 1'b1, 1'b0, 32'd0, 26'h40, "jump_to_100", rw);
    run_instr(0, 0, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'd0, "branch_neg", rw);
    checks++;
    if (bus.imem_addr !== 32'h0000_00FC) begin
      errors++;
      $display("FAIL branch_neg_target: got %h required 000000fc", bus.imem_addr);
    end
    run_instr(1, 0, 1'b1, 1'b0, 32'd0, 26'h40, "jump_back", rw);
    run_instr(0, 1, 1'b0, 1'b1, 32'd3, 26'd0, "branch_pos", rw);
    checks++;
    if (bus.imem_addr !== 32'h0000_0110) begin
      errors++;
      $display("FAIL branch_pos_target: got %h required 00000110", bus.imem_addr);
    end
  endtask

  task automatic test_jump_priority();
    int rw;
    run_instr(0, 0, 1'b0, 1'b1, 32'h1FFF_FFCB, 26'd0, "branch_far", rw);
    checks++;
    if (bus.imem_addr !== 32'h8000_0040) begin
      errors++;
      $display("FAIL branch_far_target: got %h required 80000040", bus.imem_addr);
    end
    run_instr(0, 0, 1'b1, 1'b1, 32'h0000_0100, 26'h10, "jump_priority", rw);
    checks++;
    if (bus.imem_addr !== 32'h8000_0040) begin
      errors++;
      $display("FAIL jump_priority_target: got %h required 80000040", bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    int rw;
    run_instr(0, 0, 1'b0, 1'b1, 32'h1FFF_FFEE, 26'd0, "to_top", rw);
    checks++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL top_target: got %h required fffffffc", bus.imem_addr);
    end
    run_instr(2, 0, 1'b0, 1'b0, 32'd0, 26'd0, "wrap", rw);
    checks++;
    if (bus.imem_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_target: got %h required 00000000", bus.imem_addr);
    end
  endtask

  task automatic test_random();
    int rw;
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 2) == 0), $urandom, 26'($urandom), "random", rw);
    end
  endtask

  task automatic test_async_reset();
    int rw;
    int n;
    logic [31:0] data;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_fetch: req=%b valid=%b addr=%h required 0 0 00000000",
               bus.imem_req, bus.instr_valid, bus.imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'd0;
    run_instr(0, 0, 1'b0, 1'b0, 32'd0, 26'd0, "restart_fetch", rw);
    checks++;
    if (rw != 1) begin
      errors++;
      $display("FAIL restart_idle_cycle: gap=%0d required 1", rw);
    end
    data = $urandom;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== data) begin
      errors++;
      $display("FAIL pre_reset_hold: valid=%b instr=%h required 1 %h", bus.instr_valid, bus.instr, data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== 32'd0 || bus.instr_pc !== 32'd0 ||
        bus.imem_req !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_hold: valid=%b instr=%h pc=%h req=%b required all 0",
               bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'd0;
    run_instr(1, 0, 1'b0, 1'b0, 32'd0, 26'd0, "restart_after_hold", rw);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_pc = 32'd0;
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.id_ready = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_offset = 32'd0;
    bus.jump = 1'b0;
    bus.jump_index = 26'd0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_backpressure();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
